// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request sequencer: op codes, default latencies, FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  typedef enum logic [5:0] {
    OP_FADD      = 6'd0,
    OP_FSUB      = 6'd1,
    OP_FMUL      = 6'd2,
    OP_FDIV      = 6'd3,
    OP_FCVT_W_S  = 6'd4,
    OP_FCVT_WU_S = 6'd5,
    OP_FCVT_S_W  = 6'd6,
    OP_FCVT_S_WU = 6'd7,
    OP_FSGNJ     = 6'd8,
    OP_FMIN      = 6'd9,
    OP_FMAX      = 6'd10,
    OP_FSGNJN    = 6'd11,
    OP_FSGNJX    = 6'd12,
    OP_FEQ       = 6'd13,
    OP_FLT       = 6'd14,
    OP_FLE       = 6'd15,
    OP_FCLASS    = 6'd16,
    OP_FSQRT     = 6'd17
  } fpu_op_e;

  // Default datapath latencies in cycles; every latency must stay within 1..16
  // so that LAT-1 always fits the 4-bit countdown without wrapping.
  localparam int unsigned DEF_ADD_LAT  = 3;
  localparam int unsigned DEF_MUL_LAT  = 3;
  localparam int unsigned DEF_DIV_LAT  = 12;
  localparam int unsigned DEF_SQRT_LAT = 12;
  localparam int unsigned DEF_CVT_LAT  = 2;
  localparam int unsigned SIMPLE_LAT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Request as latched at the accept edge.
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        illegal;
  } req_t;

endpackage

// File: rtl/fpu_lat_lut.sv
// Maps an FPU op code to its datapath latency and flags codes outside the legal set.
// Latency: purely combinational.
// Backpressure: none; output follows op directly.
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int unsigned ADD_LAT  = DEF_ADD_LAT,
  parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned SQRT_LAT = DEF_SQRT_LAT,
  parameter int unsigned CVT_LAT  = DEF_CVT_LAT
) (
  input  logic [5:0] op,
  output logic [4:0] lat,
  output logic       illegal
);

  // Latency table; illegal codes complete in a single cycle with no datapath use.
  always_comb begin
    lat     = 5'(SIMPLE_LAT);
    illegal = 1'b0;
    case (op)
      OP_FADD, OP_FSUB:                     lat = 5'(ADD_LAT);
      OP_FMUL:                              lat = 5'(MUL_LAT);
      OP_FDIV:                              lat = 5'(DIV_LAT);
      OP_FSQRT:                             lat = 5'(SQRT_LAT);
      OP_FCVT_W_S, OP_FCVT_WU_S,
      OP_FCVT_S_W, OP_FCVT_S_WU:            lat = 5'(CVT_LAT);
      OP_FSGNJ, OP_FMIN, OP_FMAX, OP_FSGNJN,
      OP_FSGNJX, OP_FEQ, OP_FLT, OP_FLE,
      OP_FCLASS:                            lat = 5'(SIMPLE_LAT);
      default: begin
        lat     = 5'(SIMPLE_LAT);
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fpu_seq.sv
// Single-outstanding sequencer: latches a request, drives the FPU datapath, returns its result.
// Latency: response valid exactly LAT cycles after the accept edge (LAT from fpu_lat_lut).
// Backpressure: req_ready only in IDLE without flush; response held until rsp_ready.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int unsigned ADD_LAT  = DEF_ADD_LAT,
  parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned SQRT_LAT = DEF_SQRT_LAT,
  parameter int unsigned CVT_LAT  = DEF_CVT_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [5:0]  fpu_op,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  input  logic [31:0] fpu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_nv,
  output logic        busy
);

  seq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_nv_q, rsp_nv_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic [4:0]  lut_lat;
  logic        lut_illegal;
  logic        accept;

  fpu_lat_lut #(
    .ADD_LAT  (ADD_LAT),
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT),
    .CVT_LAT  (CVT_LAT)
  ) u_lat_lut (
    .op      (req_op),
    .lat     (lut_lat),
    .illegal (lut_illegal)
  );

  // A flush in the same cycle blocks acceptance so an aborted slot is never refilled.
  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  // Next-state: flush dominates everything; otherwise walk IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_data_d  = rsp_data_q;
    rsp_nv_d    = rsp_nv_q;
    rsp_valid_d = rsp_valid_q;
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = 4'd0;
      rsp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_d.op      = req_op;
            req_d.rs1     = req_rs1;
            req_d.rs2     = req_rs2;
            req_d.rd      = req_rd;
            req_d.illegal = lut_illegal;
            // Latency is 1..16, so LAT-1 always fits in four bits.
            cnt_d         = 4'(lut_lat - 5'd1);
            state_d       = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            // Illegal ops never touch the datapath; their result is forced to zero.
            rsp_data_d  = req_q.illegal ? 32'd0 : fpu_result;
            rsp_nv_d    = req_q.illegal;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset that overrides flush and requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      rsp_data_q  <= 32'd0;
      rsp_nv_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nv_q    <= rsp_nv_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Datapath operands come straight from the latched request so they stay put until the next accept.
  assign fpu_op    = req_q.op;
  assign fpu_rs1   = req_q.rs1;
  assign fpu_rs2   = req_q.rs2;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = req_q.rd;
  assign rsp_nv    = rsp_nv_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: directed scenarios with literal expectations plus a randomized run.
// Latency: a transaction-level model predicts outputs every cycle.
// Backpressure: rsp_ready and flush are exercised by both directed and random stimulus.
module tb_fpu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic [5:0]  fpu_op;
  logic [31:0] fpu_rs1;
  logic [31:0] fpu_rs2;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_nv;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .fpu_op     (fpu_op),
    .fpu_rs1    (fpu_rs1),
    .fpu_rs2    (fpu_rs2),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_nv     (rsp_nv),
    .busy       (busy)
  );

  // Stand-in datapath: 1.0+2.0 gives 3.0, anything else an operand/op-dependent scramble.
  function automatic logic [31:0] dp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 6'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + ({26'd0, op} * 32'h9E37_79B1) + 32'h1234_5677;
  endfunction

  assign fpu_result = dp(fpu_op, fpu_rs1, fpu_rs2);

  // Latency table with default parameters.
  function automatic int ref_lat(input logic [5:0] op);
    if (op <= 6'd1) return 3;
    if (op == 6'd2) return 3;
    if (op == 6'd3) return 12;
    if (op <= 6'd7) return 2;
    if (op <= 6'd16) return 1;
    if (op == 6'd17) return 12;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one request outstanding, response due once its age reaches its latency.
  logic        m_init = 1'b0;
  logic        m_busy;
  int          m_age;
  int          m_lat;
  logic [5:0]  m_fop;
  logic [31:0] m_frs1;
  logic [31:0] m_frs2;
  logic [4:0]  m_rd;

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1;
      m_busy <= 1'b0;
      m_age  <= 0;
      m_lat  <= 1;
      m_fop  <= 6'd0;
      m_frs1 <= 32'd0;
      m_frs2 <= 32'd0;
      m_rd   <= 5'd0;
    end else if (m_init) begin
      if (flush) begin
        m_busy <= 1'b0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_busy <= 1'b1;
          m_age  <= 0;
          m_lat  <= ref_lat(req_op);
          m_fop  <= req_op;
          m_frs1 <= req_rs1;
          m_frs2 <= req_rs2;
          m_rd   <= req_rd;
        end
      end else if (m_age >= m_lat && rsp_ready) begin
        m_busy <= 1'b0;
      end else if (m_age < 100) begin
        m_age <= m_age + 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      logic ev;
      ev = m_busy && (m_age >= m_lat);
      chk("m_req_ready", 32'(req_ready), 32'(!m_busy && !flush));
      chk("m_busy",      32'(busy),      32'(m_busy));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("m_fpu_op",    32'(fpu_op),    32'(m_fop));
      chk("m_fpu_rs1",   fpu_rs1,        m_frs1);
      chk("m_fpu_rs2",   fpu_rs2,        m_frs2);
      if (ev) begin
        chk("m_rsp_rd",   32'(rsp_rd),   32'(m_rd));
        chk("m_rsp_nv",   32'(rsp_nv),   32'(m_fop > 6'd17));
        chk("m_rsp_data", rsp_data,      (m_fop > 6'd17) ? 32'd0 : dp(m_fop, m_frs1, m_frs2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the accept edge until rsp_valid; -1 if it never comes.
  task automatic wait_rsp(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
  endtask

  task automatic release_rsp();
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data,       32'd0);
    chk({tag, "_rsp_rd"},    32'(rsp_rd),    32'd0);
    chk({tag, "_rsp_nv"},    32'(rsp_nv),    32'd0);
    chk({tag, "_fpu_op"},    32'(fpu_op),    32'd0);
    chk({tag, "_fpu_rs1"},   fpu_rs1,        32'd0);
    chk({tag, "_fpu_rs2"},   fpu_rs2,        32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1; req_valid = 1'b0; req_op = 6'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    req_rd = 5'd0; flush = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Add 1.0 + 2.0
    tick();
    drive(6'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    chk("add_lat",  32'(n),        32'd3);
    chk("add_data", rsp_data,      32'h4040_0000);
    chk("add_rd",   32'(rsp_rd),   32'd5);
    chk("add_nv",   32'(rsp_nv),   32'd0);
    release_rsp();

    // Divide with a stalled consumer
    drive(6'd3, 32'h4120_0000, 32'h4000_0000, 5'd9);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    chk("div_lat", 32'(n), 32'd12);
    held = rsp_data;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("div_hold_valid", 32'(rsp_valid), 32'd1);
      chk("div_hold_data",  rsp_data,       held);
      chk("div_hold_rd",    32'(rsp_rd),    32'd9);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("div_exit_busy",  32'(busy),      32'd0);
    chk("div_exit_valid", 32'(rsp_valid), 32'd0);

    // Illegal op code
    tick();
    drive(6'd40, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd3);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    chk("ill_lat",  32'(n),      32'd1);
    chk("ill_data", rsp_data,    32'd0);
    chk("ill_nv",   32'(rsp_nv), 32'd1);
    chk("ill_rd",   32'(rsp_rd), 32'd3);
    release_rsp();

    // Flush in the middle of a divide, then a one-cycle fmin
    drive(6'd3, 32'h3F80_0000, 32'h4040_0000, 5'd11);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",  32'(busy),      32'd0);
    chk("flush_ready", 32'(req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("flush_no_rsp", 32'(cnt), 32'd0);
    a = 32'h4080_0000;
    b = 32'hC000_0000;
    tick();
    drive(6'd9, a, b, 5'd20);
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    chk("fmin_lat",  32'(n),      32'd1);
    chk("fmin_data", rsp_data,    dp(6'd9, a, b));
    chk("fmin_nv",   32'(rsp_nv), 32'd0);
    chk("fmin_rd",   32'(rsp_rd), 32'd20);
    release_rsp();

    // Flush together with a request in IDLE
    flush = 1'b1;
    drive(6'd2, 32'h1111_1111, 32'h2222_2222, 5'd1);
    @(negedge clk);
    chk("cont_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("cont_busy", 32'(busy), 32'd0);

    // Reset in the middle of EXEC
    tick();
    drive(6'd3, 32'h5555_AAAA, 32'h0F0F_F0F0, 5'd17);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk_all_zero("rst_exec");
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready", 32'(req_ready), 32'd1);

    // Back-to-back: second request held valid through EXEC and RESP
    tick();
    drive(6'd0, 32'h0000_1234, 32'h0000_5678, 5'd7);
    tick();
    a = 32'h3FC0_0000;
    b = 32'h4020_0000;
    drive(6'd2, a, b, 5'd12);
    n = -1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (req_ready) cnt++;
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    chk("b2b_lat",      32'(n),   32'd3);
    chk("b2b_rd_first", 32'(rsp_rd), 32'd7);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      if (req_ready) cnt++;
    end
    chk("b2b_no_ready", 32'(cnt), 32'd0);
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("b2b_exit_busy",  32'(busy),      32'd0);
    chk("b2b_exit_ready", 32'(req_ready), 32'd1);
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    wait_rsp(n);
    chk("b2b2_lat",  32'(n),      32'd3);
    chk("b2b2_rd",   32'(rsp_rd), 32'd12);
    chk("b2b2_data", rsp_data,    dp(6'd2, a, b));
    release_rsp();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_op    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 17));
      req_rs1   = $urandom;
      req_rs2   = $urandom;
      req_rd    = 5'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
